// File: rtl/step_ctrl_pkg.sv
// Shared encodings for the CPU step controller: FSM states, mode_sel
// decodes and the default pushbutton debounce length.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_STOP = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  localparam logic [19:0] DEBOUNCE_DEFAULT = 20'd500_000;

  // Map a mode_sel value to the state that mode requests; 11 behaves as halt.
  function automatic state_t mode_target(input logic [1:0] mode);
    state_t tgt;
    case (mode)
      MODE_RUN:  tgt = S_RUN;
      MODE_STEP: tgt = S_STEP;
      default:   tgt = S_HALT;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_btn_debouncer.sv
// Pushbutton conditioning: two-flop synchroniser, stability counter and a
// registered one-cycle pulse on each accepted rising level.
import step_ctrl_pkg::*;

module btn_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = int'(DEBOUNCE_DEFAULT)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          press_r;

  // Two-flop synchroniser bringing the raw button into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
  // a 0->1 acceptance produces a single press pulse, so a held button pulses once.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable  <= 1'b0;
      cnt     <= '0;
      press_r <= 1'b0;
    end else begin
      press_r <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable  <= sync2;
        cnt     <= '0;
        press_r <= sync2;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable controller: turns divider ticks (RUN) or debounced button
// presses (STEP) into single-cycle cpu_en pulses and counts them.
// Optional feature macro: BREAKPOINT_EN (PC breakpoint stops a RUN).
import step_ctrl_pkg::*;

module cpu_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = int'(DEBOUNCE_DEFAULT),
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             tick_in,
  input  logic [1:0]       mode_sel,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      bp_addr,
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       state_out,
  output logic             bp_hit
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic             tick_q;
  logic             tick_p;
  logic             press_p;
  logic             bp_match;
  logic             cpu_en_r;
  logic [CNT_W-1:0] count_r;
  logic             bp_hit_r;
  state_t           target;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clock_in),
    .reset(reset),
    .btn  (step_btn),
    .press(press_p)
  );

  // Remember the previous divider level so its rising edge can be found.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_in;
    end
  end

  assign tick_p = tick_in & ~tick_q;
  assign target = mode_target(mode_sel);

`ifdef BREAKPOINT_EN
  assign bp_match = (pc_in == bp_addr);
`else
  logic unused_bp;
  assign bp_match  = 1'b0;
  assign unused_bp = ^{pc_in, bp_addr};
`endif

  // Mode FSM with registered enable, pulse counter and sticky breakpoint flag.
  // Priority inside a state: halt_req, then mode change, then pulse generation.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state    <= S_HALT;
      cpu_en_r <= 1'b0;
      count_r  <= '0;
      bp_hit_r <= 1'b0;
    end else begin
      cpu_en_r <= 1'b0;
      case (state)
        S_HALT: begin
          state <= target;
        end
        S_RUN: begin
          if (halt_req) begin
            state <= S_STOP;
          end else if (target != S_RUN) begin
            state <= target;
          end else if (tick_p && bp_match) begin
            state    <= S_STOP;
            bp_hit_r <= 1'b1;
          end else if (tick_p) begin
            cpu_en_r <= 1'b1;
            count_r  <= count_r + CNT_ONE;
          end else begin
            state <= S_RUN;
          end
        end
        S_STEP: begin
          if (halt_req) begin
            state <= S_STOP;
          end else if (target != S_STEP) begin
            state <= target;
          end else if (press_p) begin
            cpu_en_r <= 1'b1;
            count_r  <= count_r + CNT_ONE;
          end else begin
            state <= S_STEP;
          end
        end
        S_STOP: begin
          if (target == S_HALT) begin
            state    <= S_HALT;
            bp_hit_r <= 1'b0;
          end else begin
            state <= S_STOP;
          end
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

  assign cpu_en      = cpu_en_r;
  assign cycle_count = count_r;
  assign state_out   = state;
  assign bp_hit      = bp_hit_r;

endmodule
